xrek_step_scheduler: RTL and testbench

Sequencer for XREK orchestration output: takes a decomposed workflow (step count, selected agent, per-step cost estimate, cost budget) and dispatches steps one at a time to the agent execution interface. It uses a valid/ready handshake, waits for each step's result, retries failed or timed-out steps, accumulates cost against the budget, and reports completion or failure. It sits between the orchestration/routing layer and the agent execution fabric.

---
 rtl/xrek_step_scheduler_if.sv | 21 ++
 rtl/xrek_step_scheduler.sv | 166 ++++++++++++++++
 tb/tb_xrek_step_scheduler.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/xrek_step_scheduler_if.sv
// Dispatch/result channel between the step scheduler (master) and the agent
// execution fabric (slave).
interface xrek_step_scheduler_if;
    logic        dispatch_valid;
    logic        dispatch_ready;
    logic [4:0]  dispatch_step_idx;
    logic [31:0] dispatch_agent;
    logic        result_valid;
    logic        result_ok;
    logic [4:0]  result_step_idx;

    modport master (
        output dispatch_valid, dispatch_step_idx, dispatch_agent,
        input  dispatch_ready, result_valid, result_ok, result_step_idx
    );

    modport slave (
        input  dispatch_valid, dispatch_step_idx, dispatch_agent,
        output dispatch_ready, result_valid, result_ok, result_step_idx
    );
endinterface

// File: rtl/xrek_step_scheduler.sv
// Dispatches workflow steps one at a time to the agent fabric, retrying failed
// or timed-out attempts and tracking cost against a budget.
module xrek_step_scheduler #(
    parameter int unsigned MAX_STEPS      = 32,
    parameter int unsigned MAX_RETRY      = 3,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start_i,
    input  logic [7:0]                   step_count_i,
    input  logic [31:0]                  selected_agent_i,
    input  logic [31:0]                  step_cost_i,
    input  logic [31:0]                  max_cost_i,
    input  logic                         abort_i,
    xrek_step_scheduler_if.master        fab_io,
    output logic                         busy_o,
    output logic                         done_o,
    output logic                         error_o,
    output logic [1:0]                   error_code_o,
    output logic [7:0]                   completed_steps_o,
    output logic [31:0]                  accumulated_cost_o
);

    localparam logic [5:0]  MaxStepsW   = 6'(MAX_STEPS);
    localparam logic [3:0]  LastRetry   = 4'(MAX_RETRY - 1);
    localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {StIdle, StDispatch, StWait, StFinish, StFail} state_e;

    state_e      state_q, state_d;
    logic [5:0]  n_q, n_d, idx_q, idx_d;
    logic [3:0]  retry_q, retry_d;
    logic [15:0] timer_q, timer_d;
    logic [31:0] agent_q, agent_d, cost_q, cost_d, max_cost_q, max_cost_d;
    logic [31:0] acc_q, acc_d;
    logic [7:0]  completed_q, completed_d;
    logic        error_q, error_d;
    logic [1:0]  code_q, code_d;

    logic [32:0] sum33;
    logic        over_budget, match;
    logic [5:0]  n_load;

    assign sum33       = {1'b0, acc_q} + {1'b0, cost_q};
    assign over_budget = sum33 > {1'b0, max_cost_q};
    assign match       = fab_io.result_valid && (fab_io.result_step_idx == idx_q[4:0]);
    assign n_load      = (step_count_i > {2'b00, MaxStepsW}) ? MaxStepsW : step_count_i[5:0];

    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        idx_d       = idx_q;
        retry_d     = retry_q;
        timer_d     = timer_q;
        agent_d     = agent_q;
        cost_d      = cost_q;
        max_cost_d  = max_cost_q;
        acc_d       = acc_q;
        completed_d = completed_q;
        error_d     = error_q;
        code_d      = code_q;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    agent_d     = selected_agent_i;
                    cost_d      = step_cost_i;
                    max_cost_d  = max_cost_i;
                    n_d         = n_load;
                    idx_d       = '0;
                    retry_d     = '0;
                    timer_d     = '0;
                    completed_d = '0;
                    acc_d       = '0;
                    error_d     = 1'b0;
                    code_d      = 2'd0;
                    state_d     = (n_load == 6'd0) ? StFinish : StDispatch;
                end
            end
            StDispatch: begin
                if (abort_i) begin
                    state_d = StFail;
                    error_d = 1'b1;
                    code_d  = 2'd3;
                end else if (over_budget) begin
                    state_d = StFail;
                    error_d = 1'b1;
                    code_d  = 2'd2;
                end else if (fab_io.dispatch_ready) begin
                    state_d = StWait;
                    timer_d = '0;
                end
            end
            StWait: begin
                timer_d = timer_q + 16'd1;
                // Priority: abort, then a matching result, then timeout expiry.
                if (abort_i) begin
                    state_d = StFail;
                    error_d = 1'b1;
                    code_d  = 2'd3;
                end else if (match && fab_io.result_ok) begin
                    completed_d = completed_q + 8'd1;
                    acc_d       = sum33[32] ? 32'hFFFF_FFFF : sum33[31:0];
                    retry_d     = '0;
                    idx_d       = idx_q + 6'd1;
                    state_d     = (idx_q + 6'd1 == n_q) ? StFinish : StDispatch;
                end else if (match || (timer_q == TimeoutLast)) begin
                    retry_d = retry_q + 4'd1;
                    if (retry_q == LastRetry) begin
                        state_d = StFail;
                        error_d = 1'b1;
                        code_d  = 2'd1;
                    end else begin
                        state_d = StDispatch;
                    end
                end
            end
            StFinish: state_d = StIdle;
            StFail:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            n_q         <= '0;
            idx_q       <= '0;
            retry_q     <= '0;
            timer_q     <= '0;
            agent_q     <= '0;
            cost_q      <= '0;
            max_cost_q  <= '0;
            acc_q       <= '0;
            completed_q <= '0;
            error_q     <= 1'b0;
            code_q      <= 2'd0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            idx_q       <= idx_d;
            retry_q     <= retry_d;
            timer_q     <= timer_d;
            agent_q     <= agent_d;
            cost_q      <= cost_d;
            max_cost_q  <= max_cost_d;
            acc_q       <= acc_d;
            completed_q <= completed_d;
            error_q     <= error_d;
            code_q      <= code_d;
        end
    end

    assign fab_io.dispatch_valid    = (state_q == StDispatch) && !over_budget;
    assign fab_io.dispatch_step_idx = idx_q[4:0];
    assign fab_io.dispatch_agent    = agent_q;

    assign busy_o             = (state_q != StIdle);
    assign done_o             = (state_q == StFinish) || (state_q == StFail);
    assign error_o            = error_q;
    assign error_code_o       = code_q;
    assign completed_steps_o  = completed_q;
    assign accumulated_cost_o = acc_q;

endmodule

// File: tb/tb_xrek_step_scheduler.sv
// Directed bench for xrek_step_scheduler: success, clamp, retry, timeout,
// budget, abort and reset scenarios with hand-computed expectations.
module tb_xrek_step_scheduler;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  step_count = '0;
    logic [31:0] selected_agent = '0;
    logic [31:0] step_cost = '0;
    logic [31:0] max_cost = '0;
    logic        abort = 1'b0;
    logic        busy, done, error;
    logic [1:0]  error_code;
    logic [7:0]  completed_steps;
    logic [31:0] accumulated_cost;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int hs_cnt = 0;
    int hs0, t0, t1;

    xrek_step_scheduler_if fab();

    xrek_step_scheduler #(
        .MAX_STEPS      (32),
        .MAX_RETRY      (3),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .start_i            (start),
        .step_count_i       (step_count),
        .selected_agent_i   (selected_agent),
        .step_cost_i        (step_cost),
        .max_cost_i         (max_cost),
        .abort_i            (abort),
        .fab_io             (fab),
        .busy_o             (busy),
        .done_o             (done),
        .error_o            (error),
        .error_code_o       (error_code),
        .completed_steps_o  (completed_steps),
        .accumulated_cost_o (accumulated_cost)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!rst && fab.dispatch_valid && fab.dispatch_ready) hs_cnt = hs_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [7:0] cnt, input logic [31:0] agent,
                            input logic [31:0] cost, input logic [31:0] maxc);
        step_count     = cnt;
        selected_agent = agent;
        step_cost      = cost;
        max_cost       = maxc;
        start          = 1'b1;
        hs0            = hs_cnt;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_offer(input int exp_idx);
        for (int i = 0; i < 40 && !fab.dispatch_valid; i++) @(negedge clk);
        check("offer_seen", 32'(fab.dispatch_valid), 1);
        check("offer_idx", 32'(fab.dispatch_step_idx), 32'(exp_idx));
    endtask

    task automatic respond(input int idx, input logic ok, input int gap);
        repeat (gap) @(negedge clk);
        fab.result_valid    = 1'b1;
        fab.result_ok       = ok;
        fab.result_step_idx = 5'(idx);
        @(negedge clk);
        fab.result_valid = 1'b0;
        fab.result_ok    = 1'b0;
    endtask

    initial begin
        fab.dispatch_ready  = 1'b1;
        fab.result_valid    = 1'b0;
        fab.result_ok       = 1'b0;
        fab.result_step_idx = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_error", 32'(error), 0);
        check("rst_code", 32'(error_code), 0);
        check("rst_valid", 32'(fab.dispatch_valid), 0);
        check("rst_agent", fab.dispatch_agent, 0);
        check("rst_idx", 32'(fab.dispatch_step_idx), 0);
        check("rst_cost", accumulated_cost, 0);

        // Three-step success
        do_start(8'd3, 32'hA5A5_0001, 32'd10, 32'd100);
        check("s3_busy", 32'(busy), 1);
        check("s3_valid_t1", 32'(fab.dispatch_valid), 1);
        for (int i = 0; i < 3; i++) begin
            wait_offer(i);
            respond(i, 1'b1, 2);
        end
        check("s3_done", 32'(done), 1);
        check("s3_error", 32'(error), 0);
        check("s3_completed", 32'(completed_steps), 3);
        check("s3_cost", accumulated_cost, 30);
        check("s3_agent", fab.dispatch_agent, 32'hA5A5_0001);
        check("s3_hs", 32'(hs_cnt - hs0), 3);
        @(negedge clk);
        check("s3_idle", 32'(busy), 0);
        check("s3_done_pulse", 32'(done), 0);

        // Zero steps
        do_start(8'd0, 32'd1, 32'd10, 32'd100);
        check("z_done", 32'(done), 1);
        check("z_valid", 32'(fab.dispatch_valid), 0);
        @(negedge clk);
        check("z_hs", 32'(hs_cnt - hs0), 0);

        // Clamp 40 -> 32
        do_start(8'd40, 32'd2, 32'd1, 32'd1000);
        for (int i = 0; i < 32; i++) begin
            wait_offer(i);
            respond(i, 1'b1, 1);
        end
        check("c_done", 32'(done), 1);
        check("c_completed", 32'(completed_steps), 32);
        check("c_hs", 32'(hs_cnt - hs0), 32);
        @(negedge clk);

        // Retry: step 1 NACKs twice then succeeds
        do_start(8'd3, 32'd3, 32'd10, 32'd100);
        wait_offer(0);
        respond(0, 1'b1, 1);
        for (int i = 0; i < 2; i++) begin
            wait_offer(1);
            respond(1, 1'b0, 1);
        end
        wait_offer(1);
        respond(1, 1'b1, 1);
        wait_offer(2);
        respond(2, 1'b1, 1);
        check("r_done", 32'(done), 1);
        check("r_error", 32'(error), 0);
        check("r_completed", 32'(completed_steps), 3);
        check("r_hs", 32'(hs_cnt - hs0), 5);
        @(negedge clk);

        // Retry exhaustion
        do_start(8'd3, 32'd4, 32'd10, 32'd100);
        wait_offer(0);
        respond(0, 1'b1, 1);
        for (int i = 0; i < 3; i++) begin
            wait_offer(1);
            respond(1, 1'b0, 1);
        end
        check("x_done", 32'(done), 1);
        check("x_error", 32'(error), 1);
        check("x_code", 32'(error_code), 1);
        check("x_completed", 32'(completed_steps), 1);
        @(negedge clk);
        check("x_idle", 32'(busy), 0);
        check("x_error_sticky", 32'(error), 1);
        check("x_code_sticky", 32'(error_code), 1);

        // Timeout: re-offer every 9 cycles, fail after three attempts
        do_start(8'd2, 32'd5, 32'd5, 32'd100);
        check("t_error_cleared", 32'(error), 0);
        wait_offer(0);
        t0 = cyc;
        @(negedge clk);
        wait_offer(0);
        t1 = cyc;
        check("t_period1", 32'(t1 - t0), 9);
        @(negedge clk);
        wait_offer(0);
        t0 = cyc;
        check("t_period2", 32'(t0 - t1), 9);
        repeat (9) @(negedge clk);
        check("t_done", 32'(done), 1);
        check("t_code", 32'(error_code), 1);
        check("t_completed", 32'(completed_steps), 0);
        @(negedge clk);

        // Result on the expiry cycle wins over timeout
        do_start(8'd1, 32'd6, 32'd5, 32'd100);
        wait_offer(0);
        respond(0, 1'b1, 8);
        check("e_done", 32'(done), 1);
        check("e_error", 32'(error), 0);
        check("e_completed", 32'(completed_steps), 1);
        check("e_hs", 32'(hs_cnt - hs0), 1);
        @(negedge clk);

        // Budget exceeded before third step
        do_start(8'd4, 32'd7, 32'd40, 32'd100);
        wait_offer(0);
        respond(0, 1'b1, 1);
        wait_offer(1);
        respond(1, 1'b1, 1);
        check("b_no_offer", 32'(fab.dispatch_valid), 0);
        @(negedge clk);
        check("b_done", 32'(done), 1);
        check("b_code", 32'(error_code), 2);
        check("b_cost", accumulated_cost, 80);
        check("b_hs", 32'(hs_cnt - hs0), 2);
        @(negedge clk);

        // Saturating cost and 33-bit budget compare
        do_start(8'd3, 32'd8, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_offer(0);
        respond(0, 1'b1, 1);
        check("sat_no_offer", 32'(fab.dispatch_valid), 0);
        check("sat_cost", accumulated_cost, 32'hFFFF_FFFF);
        @(negedge clk);
        check("sat_code", 32'(error_code), 2);
        check("sat_hs", 32'(hs_cnt - hs0), 1);
        @(negedge clk);

        // Abort while offer is held without ready
        fab.dispatch_ready = 1'b0;
        do_start(8'd2, 32'd9, 32'd1, 32'd100);
        check("a_valid", 32'(fab.dispatch_valid), 1);
        @(negedge clk);
        check("a_valid_held", 32'(fab.dispatch_valid), 1);
        check("a_idx_held", 32'(fab.dispatch_step_idx), 0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("a_valid_low", 32'(fab.dispatch_valid), 0);
        check("a_done", 32'(done), 1);
        check("a_code", 32'(error_code), 3);
        check("a_hs", 32'(hs_cnt - hs0), 0);
        fab.dispatch_ready = 1'b1;
        @(negedge clk);

        // Reset while waiting on step 1
        do_start(8'd3, 32'd10, 32'd10, 32'd100);
        wait_offer(0);
        respond(0, 1'b1, 1);
        wait_offer(1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mr_busy", 32'(busy), 0);
        check("mr_valid", 32'(fab.dispatch_valid), 0);
        check("mr_completed", 32'(completed_steps), 0);
        check("mr_cost", accumulated_cost, 0);
        check("mr_agent", fab.dispatch_agent, 0);
        do_start(8'd1, 32'd11, 32'd3, 32'd100);
        wait_offer(0);
        respond(0, 1'b1, 1);
        check("mr_after_done", 32'(done), 1);
        check("mr_after_completed", 32'(completed_steps), 1);
        @(negedge clk);

        // Start while busy is ignored
        do_start(8'd2, 32'h0000_00BB, 32'd7, 32'd100);
        wait_offer(0);
        @(negedge clk);
        step_count     = 8'd5;
        selected_agent = 32'h0000_00CC;
        step_cost      = 32'd99;
        start          = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("sb_agent", fab.dispatch_agent, 32'h0000_00BB);
        respond(0, 1'b1, 1);
        wait_offer(1);
        respond(1, 1'b1, 1);
        check("sb_done", 32'(done), 1);
        check("sb_completed", 32'(completed_steps), 2);
        check("sb_cost", accumulated_cost, 14);
        check("sb_hs", 32'(hs_cnt - hs0), 2);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
